pattern_mode_sequencer: RTL
===========================

// Module: pattern_mode_sequencer
// PURPOSE
//  Frame-synchronous controller for the test-pattern generator ahead of the DVI TX.
//  Picks the pattern mode and single-colour value. Auto mode steps through modes
//  every FRAMES_PER_MODE frames; a debounced push-button forces an advance.
//  Every change is applied only at a frame boundary (end of VS pulse), so no frame tears.
// PARAMETERS
//  NUM_MODES        4        modes cycled, 0..NUM_MODES-1 (max 8)
//  FRAMES_PER_MODE  256      frames shown per mode in auto mode (>=1, <=1023)
//  DEB_CYCLES       1485000  stable cycles needed to accept a button level (20 ms @ 74.25 MHz)
// PORTS
//  I_pxl_clk   in   1   pixel clock; sole clock
//  I_rst       in   1   asynchronous reset, active-high
//  I_vs        in   1   VS from pattern generator, I_pxl_clk domain
//  I_vs_pol    in   1   VS polarity: 1 = active-high, 0 = active-low
//  I_btn       in   1   raw push-button, asynchronous, 1 = pressed
//  I_auto_en   in   1   1 = timed auto-advance enabled
//  O_mode      out  3   pattern mode select to generator
//  O_single_r  out  8   single-colour red
//  O_single_g  out  8   single-colour green
//  O_single_b  out  8   single-colour blue
//  O_frame_cnt out  10  frames elapsed in current mode
//  O_mode_chg  out  1   one-cycle pulse when O_mode updates
// BEHAVIOUR
//  Reset: O_mode=0, O_frame_cnt=0, O_mode_chg=0, pending=0, debounced btn=0,
//   colour outputs = reset colour (see CONFIGURATION); all registers async-cleared.
//  vs_act = I_vs ~^ I_vs_pol; vs_r = vs_act registered. frame_end = vs_r & ~vs_act (1 cycle).
//  Button: 2-FF synchroniser -> counter; btn_db takes new level after DEB_CYCLES
//   consecutive equal samples; counter clears on any mismatch. Rising edge of btn_db -> press.
//  FSM: S_HOLD (no request) / S_PEND (advance requested, waiting for frame_end).
//   S_HOLD->S_PEND on press. S_PEND->S_HOLD on frame_end (advance applied).
//   Extra presses in S_PEND are absorbed: one advance per boundary, at most.
//  At frame_end (registered, outputs change the cycle after frame_end is high):
//   advance = (state==S_PEND) | (I_auto_en & O_frame_cnt==FRAMES_PER_MODE-1).
//   advance: O_mode = (O_mode==NUM_MODES-1) ? 0 : O_mode+1; O_frame_cnt=0; O_mode_chg=1.
//   else if I_auto_en: O_frame_cnt+1. Press and auto expiry together = a single advance.
//  Press on the same cycle as frame_end: goes to S_PEND, applied at the next frame_end.
//  I_auto_en=0: O_frame_cnt held at 0; only presses advance. 1->0 mid-count clears the count.
//  No VS activity: mode frozen, a pending request is held indefinitely.
//  Reset mid-operation: pending request and count are discarded; restart at mode 0.
// CONFIGURATION
//  PATTERN_SEQ_COLOR_CYCLE_EN defined: 2-bit colour index, reset 0; +1 at each O_mode wrap
//   NUM_MODES-1 -> 0; index 0..3 -> R(255,0,0) G(0,255,0) B(0,0,255) W(255,255,255), wraps.
//   Reset colour = red.
//  Not defined: O_single_{r,g,b} are constant (0,255,0). No index register is built.
// TESTING (NUM_MODES=4, FRAMES_PER_MODE=4, DEB_CYCLES=8, I_vs_pol=1, 100-cycle frames)
//  1 Reset, I_auto_en=1, 17 frames -> O_mode 0,1,2,3,0 after frame_ends 4,8,12,16;
//    O_mode_chg one pulse each, the cycle after frame_end.
//  2 I_auto_en=0, btn high 12 cycles mid-frame -> O_mode 0->1 only at next frame_end;
//    O_frame_cnt stays 0.
//  3 Bounce: btn toggles every 3 cycles for 40 cycles, then low -> no press, O_mode unchanged.
//  4 Two clean presses in one frame -> single advance; a press on the frame_end cycle
//    applies one frame later.
//  5 Auto count at 3 plus a pending press, then frame_end -> O_mode +1 (not +2), count 0.
//  6 I_rst pulse with pending set, count 2 -> all outputs at reset values, no late advance;
//    with _EN: 4 wraps give R,G,B,W,R.

Source files
------------

// File: rtl/pattern_mode_sequencer.sv
// pattern_mode_sequencer: frame-synchronous pattern mode / single-colour selector for the test-pattern generator (optional PATTERN_SEQ_COLOR_CYCLE_EN)
module pattern_mode_sequencer #(
    parameter int NUM_MODES       = 4,
    parameter int FRAMES_PER_MODE = 256,
    parameter int DEB_CYCLES      = 1485000
) (
    input  logic       I_pxl_clk,
    input  logic       I_rst,
    input  logic       I_vs,
    input  logic       I_vs_pol,
    input  logic       I_btn,
    input  logic       I_auto_en,
    output logic [2:0] O_mode,
    output logic [7:0] O_single_r,
    output logic [7:0] O_single_g,
    output logic [7:0] O_single_b,
    output logic [9:0] O_frame_cnt,
    output logic       O_mode_chg
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [2:0] MODE_LAST = 3'(NUM_MODES - 1);
    localparam logic [9:0] FRAME_LAST = 10'(FRAMES_PER_MODE - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic {S_HOLD, S_PEND} state_t;

    state_t        state, state_nxt;
    logic          vs_act, vs_r, frame_end;
    logic          btn_s1, btn_s2, btn_db, btn_db_r, press, advance;
    logic [DW-1:0] deb_cnt;

    assign vs_act    = I_vs ~^ I_vs_pol;
    assign frame_end = vs_r & ~vs_act;
    assign press     = btn_db & ~btn_db_r;
    assign advance   = frame_end & ((state == S_PEND) | (I_auto_en & (O_frame_cnt == FRAME_LAST)));

    // VS edge tracking, button synchroniser and debounce
    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            vs_r     <= 1'b0;
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_r <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            vs_r     <= vs_act;
            btn_s1   <= I_btn;
            btn_s2   <= btn_s1;
            btn_db_r <= btn_db;
            if (btn_s2 == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                btn_db  <= btn_s2;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // request state register
    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) state <= S_HOLD;
        else       state <= state_nxt;
    end

    // a press arms a request; the next frame boundary consumes it, extra presses are absorbed
    always_comb begin
        state_nxt = state;
        state_nxt = (state == S_HOLD) ? (press ? S_PEND : S_HOLD) : (frame_end ? S_HOLD : S_PEND);
    end

    // mode, frame count and change pulse, updated only at frame boundaries
    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst) begin
            O_mode      <= '0;
            O_frame_cnt <= '0;
            O_mode_chg  <= 1'b0;
        end else begin
            O_mode_chg <= advance;
            if (advance) begin
                O_mode      <= (O_mode == MODE_LAST) ? 3'd0 : O_mode + 3'd1;
                O_frame_cnt <= '0;
            end else if (!I_auto_en) begin
                O_frame_cnt <= '0;
            end else if (frame_end) begin
                O_frame_cnt <= O_frame_cnt + 10'd1;
            end
        end
    end

`ifdef PATTERN_SEQ_COLOR_CYCLE_EN
    logic [1:0] col_idx;

    // colour index steps each time the mode sequence wraps back to 0
    always_ff @(posedge I_pxl_clk or posedge I_rst) begin
        if (I_rst)                              col_idx <= 2'd0;
        else if (advance && O_mode == MODE_LAST) col_idx <= col_idx + 2'd1;
    end

    assign O_single_r = (col_idx == 2'd0 || col_idx == 2'd3) ? 8'hFF : 8'h00;
    assign O_single_g = (col_idx == 2'd1 || col_idx == 2'd3) ? 8'hFF : 8'h00;
    assign O_single_b = (col_idx == 2'd2 || col_idx == 2'd3) ? 8'hFF : 8'h00;
`else
    assign O_single_r = 8'h00;
    assign O_single_g = 8'hFF;
    assign O_single_b = 8'h00;
`endif
endmodule
